// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory read responder.
package imem_pkg;

   typedef enum logic {IDLE, BURST} imem_state_t;

   // addi x0, x0, 0: harmless filler for fetches outside the memory image
   localparam logic [31:0] NOP_INSN    = 32'h0000_0013;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

endpackage

// File: rtl/imem_rom.sv
// Instruction word store: DEPTH x 32 array with an asynchronous read port.
// in_range flags byte addresses that land inside the array; rdata is 0 otherwise.
module imem_rom #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter string       INIT_FILE = ""
) (
   input  logic [31:0] addr,
   output logic [31:0] rdata,
   output logic        in_range
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem [DEPTH];
   logic [31:0] offset;
   logic [29:0] word;
   logic        unused_offset_lsbs;

   // Word select and range check; byte-lane bits are ignored
   always_comb begin
      offset   = addr - BASE_ADDR;
      word     = offset[31:2];
      in_range = (addr >= BASE_ADDR) && ({2'b00, word} < DEPTH);
      rdata    = in_range ? mem[word[AW-1:0]] : 32'h0;
   end

   assign unused_offset_lsbs = ^offset[1:0];

endmodule

// File: rtl/imem_burst_responder.sv
// Memory end of the instruction fetch read channel. Accepts one burst request at a time and
// returns one registered word per handshake, with rlast on the final beat. flush abandons the
// remainder of a burst. Optional feature macro: IMEM_RRESP_EN (adds rresp, out-of-range beats
// report SLVERR with rdata=0 instead of returning a nop).
module imem_burst_responder
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int unsigned LEN_W     = 4,
   parameter string       INIT_FILE = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      araddr,
   input  logic [LEN_W-1:0] arlen,
   input  logic             arvalid,
   output logic             arready,
   output logic [31:0]      rdata,
   output logic             rvalid,
   input  logic             rready,
   output logic             rlast,
`ifdef IMEM_RRESP_EN
   output logic [1:0]       rresp,
`endif
   input  logic             flush
);

   imem_state_t      state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             arready_q, arready_d;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q, rlast_d;
   logic [31:0]      rdata_q;
   logic             load_beat;
   logic             ar_hs, r_hs;
   logic [31:0]      rom_addr, rom_rdata, beat_data;
   logic             rom_in_range;

   imem_rom #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR),
      .INIT_FILE (INIT_FILE)
   ) u_rom (
      .addr     (rom_addr),
      .rdata    (rom_rdata),
      .in_range (rom_in_range)
   );

   assign ar_hs = arvalid & arready_q;
   assign r_hs  = rvalid_q & rready;

`ifdef IMEM_RRESP_EN
   logic [1:0] rresp_q;
   logic [1:0] beat_resp;

   assign beat_data = rom_rdata;
   assign beat_resp = rom_in_range ? RESP_OKAY : RESP_SLVERR;

   // Response code travels with the beat it describes
   always_ff @(posedge clk) begin
      if (!rst_n)         rresp_q <= RESP_OKAY;
      else if (load_beat) rresp_q <= beat_resp;
   end

   assign rresp = rresp_q;
`else
   assign beat_data = rom_in_range ? rom_rdata : NOP_INSN;
`endif

   // Next state: request capture in IDLE, beat advance / flush / completion in BURST
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      load_beat   = 1'b0;
      rom_addr    = addr_q;

      unique case (state_q)
         IDLE: begin
            // First beat is read straight off the request so it is valid one cycle later
            rom_addr = araddr;
            if (ar_hs) begin
               state_d     = BURST;
               load_beat   = 1'b1;
               rvalid_d    = 1'b1;
               rlast_d     = (arlen == '0);
               addr_d      = araddr + 32'd4;
               remaining_d = arlen;
            end
         end
         BURST: begin
            if (flush) begin
               // Any beat handshaken this cycle still counts; nothing further is sent
               state_d     = IDLE;
               rvalid_d    = 1'b0;
               rlast_d     = 1'b0;
               remaining_d = '0;
            end else if (r_hs) begin
               if (rlast_q) begin
                  state_d  = IDLE;
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
               end else begin
                  load_beat   = 1'b1;
                  addr_d      = addr_q + 32'd4;
                  remaining_d = remaining_q - 1'b1;
                  rlast_d     = (remaining_q == LEN_W'(1));
               end
            end
         end
         default: begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
         end
      endcase

      arready_d = (state_d == IDLE);
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= 32'h0;
         remaining_q <= '0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rlast_q     <= rlast_d;
      end
   end

   // Beat data register; only reloads when a new beat is presented so stalls hold it
   always_ff @(posedge clk) begin
      if (!rst_n)         rdata_q <= 32'h0;
      else if (load_beat) rdata_q <= beat_data;
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rdata   = rdata_q;

endmodule

// File: tb/tb_imem_burst_responder.sv
// Self-checking bench for imem_burst_responder: directed scenarios followed by random bursts,
// each beat compared against a word-array model of the instruction memory.
module tb_imem_burst_responder;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [31:0]      araddr = 32'h0;
   logic [LEN_W-1:0] arlen = '0;
   logic             arvalid = 1'b0;
   logic             arready;
   logic [31:0]      rdata;
   logic             rvalid;
   logic             rready = 1'b0;
   logic             rlast;
   logic             flush = 1'b0;
`ifdef IMEM_RRESP_EN
   logic [1:0]       rresp;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] model_mem [DEPTH];

   imem_burst_responder #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (32'h0),
      .LEN_W     (LEN_W),
      .INIT_FILE ("")
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .araddr  (araddr),
      .arlen   (arlen),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .rready  (rready),
      .rlast   (rlast),
`ifdef IMEM_RRESP_EN
      .rresp   (rresp),
`endif
      .flush   (flush)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      if (idx < DEPTH) return model_mem[idx];
`ifdef IMEM_RRESP_EN
      return 32'h0;
`else
      return 32'h0000_0013;
`endif
   endfunction

   function automatic logic [31:0] exp_resp(input logic [31:0] a);
      logic [31:0] idx;
      idx = a >> 2;
      return (idx < DEPTH) ? 32'h0 : 32'h2;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One full request/response exchange checked beat by beat against the model
   task automatic run_burst(input string tag, input logic [31:0] addr, input int len,
                            input int stall_pct, input int hold0, input int flush_beat,
                            input bit flush_ar);
      int          waits;
      int          k;
      int          cycles;
      int          exp_k;
      bit          done;
      bit          fl;
      logic [31:0] a;

      araddr  = addr;
      arlen   = len[LEN_W-1:0];
      arvalid = 1'b1;
      flush   = flush_ar;
      waits   = 0;
      while (arready !== 1'b1 && waits < 20) begin
         tick();
         waits++;
      end
      chk({tag, "_ar_wait"}, waits, 0);
      tick();
      arvalid = 1'b0;
      flush   = 1'b0;
      araddr  = $urandom;
      arlen   = LEN_W'($urandom);

      k      = 0;
      done   = 1'b0;
      cycles = 0;
      while (!done && cycles < 100) begin
         a = addr + 32'(4 * k);
         chk({tag, "_rvalid"}, 32'(rvalid), 1);
         chk({tag, "_rdata"}, rdata, exp_word(a));
         chk({tag, "_rlast"}, 32'(rlast), 32'(k == len));
`ifdef IMEM_RRESP_EN
         chk({tag, "_rresp"}, 32'(rresp), exp_resp(a));
`endif
         if (k == 0 && cycles < hold0) rready = 1'b0;
         else rready = ($urandom_range(99) >= stall_pct);
         fl     = (k == flush_beat) && rready;
         flush  = fl;
         tick();
         flush  = 1'b0;
         if (rready) begin
            if (fl || k == len) done = 1'b1;
            k++;
         end
         cycles++;
      end
      rready = 1'b0;
      exp_k  = (flush_beat >= 0 && flush_beat <= len) ? flush_beat + 1 : len + 1;
      chk({tag, "_done"}, 32'(done), 1);
      chk({tag, "_beats"}, k, exp_k);
      chk({tag, "_end_rvalid"}, 32'(rvalid), 0);
      chk({tag, "_end_rlast"}, 32'(rlast), 0);
      chk({tag, "_end_arready"}, 32'(arready), 1);
   endtask

   initial begin
      logic [31:0] addr;
      int          len;
      int          fb;

      for (int i = 0; i < DEPTH; i++) begin
         model_mem[i]      = $urandom;
         dut.u_rom.mem[i]  = model_mem[i];
      end

      // Reset held for three cycles
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rlast", 32'(rlast), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_arready", 32'(arready), 0);
      rst_n = 1'b1;
      chk("rel_arready_pre_edge", 32'(arready), 0);
      tick();
      chk("rel_arready", 32'(arready), 1);

      // Directed scenarios
      run_burst("b4_at_10", 32'h10, 3, 0, 0, -1, 1'b0);
      run_burst("stall_beat0", 32'h0, 1, 0, 3, -1, 1'b0);
      run_burst("flush_beat2", 32'h40, 7, 0, 0, 2, 1'b0);
      run_burst("after_flush", 32'h100, 2, 0, 0, -1, 1'b0);
      run_burst("edge_of_mem", DEPTH * 4 - 4, 1, 0, 0, -1, 1'b0);
      run_burst("single_beat", 32'h8, 0, 0, 0, -1, 1'b0);
      run_burst("flush_in_idle", 32'h24, 2, 0, 0, -1, 1'b1);
      run_burst("full_len", 32'h200, 15, 20, 0, -1, 1'b0);
      run_burst("flush_last", 32'h80, 3, 0, 0, 3, 1'b0);

      // Reset asserted while beat 1 of 4 is presented
      araddr  = 32'h20;
      arlen   = 3;
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      rready  = 1'b1;
      chk("mid_rst_beat0", rdata, model_mem[8]);
      tick();
      chk("mid_rst_beat1", rdata, model_mem[9]);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_rvalid", 32'(rvalid), 0);
      chk("mid_rst_rlast", 32'(rlast), 0);
      chk("mid_rst_rdata", rdata, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_idle_rvalid", 32'(rvalid), 0);
      end
      rready = 1'b0;
      chk("post_rst_arready", 32'(arready), 1);

      // Random bursts over in-range, edge, far and wrapping addresses
      for (int r = 0; r < 24; r++) begin
         case ($urandom_range(3))
            0:       addr = $urandom_range(DEPTH * 4 - 1);
            1:       addr = DEPTH * 4 - 4 * $urandom_range(4) + $urandom_range(3);
            2:       addr = $urandom;
            default: addr = 32'hFFFF_FFF0 + $urandom_range(15);
         endcase
         len = $urandom_range(15);
         fb  = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
         run_burst("rand", addr, len, 30, $urandom_range(2), fb, ($urandom_range(4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
